// File: rtl/chacha_pkg.sv
// Shared constants and FSM state encoding for the ChaCha stream controller.
package chacha_pkg;

   localparam int LOAD_BYTES  = 48;
   localparam int BLOCK_BYTES = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_WAIT,
      S_STREAM
   } state_e;

endpackage

// File: rtl/chacha_stream_ctl_byte_pipe_reg.sv
// Single-entry valid/ready output register: loads on i_load, drains on i_ready.
module byte_pipe_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_data,
   input  logic       i_load,
   input  logic       i_ready,
   output logic [7:0] o_data,
   output logic       o_valid
);

   logic [7:0] r_data;
   logic       r_valid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= 8'h00;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/chacha_stream_ctl.sv
// Host-side driver for the ChaCha block byte interface: loads key material,
// waits for the keystream, then XORs it onto the plaintext byte stream.
module chacha_stream_ctl
   import chacha_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] blk_data_in,
   output logic       blk_write,
   output logic       blk_read,
   input  logic [7:0] blk_data_out,
   input  logic       blk_ready,
   output logic       loaded,
   output logic [5:0] byte_idx
);

   state_e     r_state, w_state_nxt;
   logic [5:0] r_load_cnt, w_load_cnt_nxt;
   logic [5:0] r_byte_idx, w_byte_idx_nxt;
   logic       r_loaded, w_loaded_nxt;
   logic       w_can_out, w_accept, w_fire, w_load_last, w_blk_last;

   assign w_can_out   = !out_valid || out_ready;
   // A start in STREAM must not consume a keystream byte, so it blocks the handshake.
   assign in_ready    = (r_state == S_LOAD) ||
                        ((r_state == S_STREAM) && blk_ready && w_can_out && !start);
   assign w_accept    = in_valid && in_ready;
   assign w_fire      = w_accept && (r_state == S_STREAM);
   assign blk_write   = in_valid && (r_state == S_LOAD);
   assign blk_data_in = in_data;
   assign blk_read    = w_fire;
   assign w_load_last = (r_load_cnt == 6'(LOAD_BYTES - 1));
   assign w_blk_last  = (r_byte_idx == 6'(BLOCK_BYTES - 1));

   // NOTE: every signal written here is given a default first, so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_load_cnt_nxt = r_load_cnt;
      w_byte_idx_nxt = r_byte_idx;
      w_loaded_nxt   = r_loaded;
      if (start) begin
         w_state_nxt    = S_LOAD;
         w_load_cnt_nxt = ((r_state == S_LOAD) && w_accept) ? 6'd1 : 6'd0;
         w_byte_idx_nxt = 6'd0;
         w_loaded_nxt   = 1'b0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (w_accept) begin
                  if (w_load_last) begin
                     w_state_nxt    = S_SETTLE;
                     w_byte_idx_nxt = 6'd0;
                     w_loaded_nxt   = 1'b1;
                  end else begin
                     w_load_cnt_nxt = r_load_cnt + 6'd1;
                  end
               end
            end
            // A ready left over from the previous block must drop before we wait on it.
            S_SETTLE: if (!blk_ready) w_state_nxt = S_WAIT;
            S_WAIT:   if (blk_ready)  w_state_nxt = S_STREAM;
            S_STREAM: begin
               if (w_fire) begin
                  w_byte_idx_nxt = r_byte_idx + 6'd1;
                  if (w_blk_last) w_state_nxt = S_SETTLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_load_cnt <= 6'd0;
         r_byte_idx <= 6'd0;
         r_loaded   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_load_cnt <= w_load_cnt_nxt;
         r_byte_idx <= w_byte_idx_nxt;
         r_loaded   <= w_loaded_nxt;
      end
   end

   byte_pipe_reg u_out_reg (
      .clk     (clk),
      .rst     (rst),
      .i_data  (in_data ^ blk_data_out),
      .i_load  (w_fire),
      .i_ready (out_ready),
      .o_data  (out_data),
      .o_valid (out_valid)
   );

   assign loaded   = r_loaded;
   assign byte_idx = r_byte_idx;

endmodule

// File: tb/tb_chacha_stream_ctl.sv
// Directed bench for chacha_stream_ctl with a small behavioural ChaCha block model.
module tb_chacha_stream_ctl;

   logic       clk = 1'b0;
   logic       rst, start, in_valid, out_ready, blk_ready;
   logic [7:0] in_data, blk_data_out;
   logic       in_ready, out_valid, blk_write, blk_read, loaded;
   logic [7:0] out_data, blk_data_in;
   logic [5:0] byte_idx;

   always #5 clk = ~clk;

   chacha_stream_ctl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .blk_data_in  (blk_data_in),
      .blk_write    (blk_write),
      .blk_read     (blk_read),
      .blk_data_out (blk_data_out),
      .blk_ready    (blk_ready),
      .loaded       (loaded),
      .byte_idx     (byte_idx)
   );

   // Block model: ready 20 cycles after the last write; after 64 reads ready
   // lingers 2 cycles (stale), then drops for 20 cycles while the next block computes.
   logic [5:0] m_ridx;
   logic [4:0] m_cnt;
   logic [1:0] m_drop;
   logic       m_blk;

   always @(posedge clk) begin
      if (rst) begin
         blk_ready <= 1'b0;
         m_ridx    <= 6'd0;
         m_cnt     <= 5'd0;
         m_drop    <= 2'd0;
         m_blk     <= 1'b0;
      end else if (blk_write) begin
         blk_ready <= 1'b0;
         m_cnt     <= 5'd20;
         m_ridx    <= 6'd0;
         m_blk     <= 1'b0;
         m_drop    <= 2'd0;
      end else if (blk_read) begin
         m_ridx <= m_ridx + 6'd1;
         if (m_ridx == 6'd63) m_drop <= 2'd2;
      end else if (m_drop != 2'd0) begin
         m_drop <= m_drop - 2'd1;
         if (m_drop == 2'd1) begin
            blk_ready <= 1'b0;
            m_cnt     <= 5'd20;
            m_blk     <= ~m_blk;
         end
      end else if (m_cnt != 5'd0) begin
         m_cnt <= m_cnt - 5'd1;
         if (m_cnt == 5'd1) blk_ready <= 1'b1;
      end
   end

   assign blk_data_out = (m_blk ? 8'h5A : 8'hA5) ^ {2'b00, m_ridx};

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0] pt;
      logic [7:0] ct;
   } vec_t;

   localparam int N_VEC = 74;
   vec_t       tab [N_VEC];
   logic [7:0] sb [$];

   task automatic do_load(input bit gaps);
      int writes = 0;
      start    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      if (blk_write) writes++;
      next_cycle();
      start = 1'b0;
      for (int i = 0; i < 48; i++) begin
         if (gaps && (i == 10 || i == 20 || i == 30)) begin
            in_valid = 1'b0;
            @(negedge clk);
            if (blk_write) writes++;
            next_cycle();
         end
         in_valid = 1'b1;
         in_data  = 8'(i);
         @(negedge clk);
         if (blk_write) writes++;
         check("load_blk_data_in", 32'(blk_data_in), 32'(i[7:0]));
         if (i == 0) check("loaded_during_load", 32'(loaded), 32'd0);
         next_cycle();
      end
      in_valid = 1'b1;
      in_data  = 8'h99;
      @(negedge clk);
      if (blk_write) writes++;
      check("loaded_after_load", 32'(loaded), 32'd1);
      check("in_ready_after_load", 32'(in_ready), 32'd0);
      check("byte_idx_after_load", 32'(byte_idx), 32'd0);
      check("load_write_cycles", 32'(writes), 32'd48);
      in_valid = 1'b0;
      next_cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  idx, cyc, stall_left, reads, gap;
      bit  stalled, wrap_chk;

      for (int i = 0; i < 64; i++) tab[i] = '{8'(i), 8'hA5};
      tab[64] = '{8'hFF, 8'hA5};
      tab[65] = '{8'h3C, 8'h67};
      tab[66] = '{8'h00, 8'h58};
      tab[67] = '{8'h5A, 8'h03};
      for (int k = 4; k < 10; k++) tab[64 + k] = '{8'hF0, 8'hAA ^ 8'(k)};

      // Reset with random inputs
      rst = 1'b1;
      repeat (2) begin
         start     = 1'($urandom_range(0, 1));
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom_range(0, 255));
         out_ready = 1'($urandom_range(0, 1));
         next_cycle();
      end
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_blk_write", 32'(blk_write), 32'd0);
      check("rst_blk_read", 32'(blk_read), 32'd0);
      check("rst_loaded", 32'(loaded), 32'd0);
      check("rst_byte_idx", 32'(byte_idx), 32'd0);
      next_cycle();
      rst       = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      next_cycle();

      do_load(1'b0);
      do_load(1'b1);

      // Streaming through block 0, a mid-stream stall, the block wrap and part of block 1
      idx = 0; cyc = 0; stall_left = 0; reads = 0; gap = 0;
      stalled = 1'b0; wrap_chk = 1'b0;
      in_valid = 1'b1;
      while (idx < N_VEC && cyc < 3000) begin
         if (idx == 30 && !stalled) begin
            stalled    = 1'b1;
            stall_left = 5;
         end
         out_ready = (stall_left == 0);
         in_data   = tab[idx].pt;
         @(negedge clk);
         check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
         if (sb.size() > 0) begin
            if (out_ready) begin
               check("out_data", 32'(out_data), 32'(sb[0]));
               void'(sb.pop_front());
            end else begin
               check("stall_out_data", 32'(out_data), 32'(sb[0]));
               check("stall_in_ready", 32'(in_ready), 32'd0);
               check("stall_blk_read", 32'(blk_read), 32'd0);
            end
         end
         if (wrap_chk) begin
            check("wrap_byte_idx", 32'(byte_idx), 32'd0);
            check("wrap_in_ready", 32'(in_ready), 32'd0);
            wrap_chk = 1'b0;
         end
         if (blk_read) begin
            reads++;
            sb.push_back(tab[idx].ct);
            if (idx == 64) check("wrap_gap_ge_20", 32'(gap >= 20), 32'd1);
            if (idx == 63) begin
               check("block0_reads", 32'(reads), 32'd64);
               wrap_chk = 1'b1;
               gap      = 0;
            end
            idx++;
         end else begin
            gap++;
         end
         if (stall_left > 0) stall_left--;
         cyc++;
         next_cycle();
      end
      check("stream_complete", 32'(idx), 32'(N_VEC));

      // Rekey at byte_idx=10 with a pending byte under backpressure
      start     = 1'b1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h77;
      @(negedge clk);
      check("rekey_blk_read", 32'(blk_read), 32'd0);
      check("rekey_blk_write", 32'(blk_write), 32'd0);
      check("rekey_idx_before", 32'(byte_idx), 32'd10);
      check("rekey_out_valid", 32'(out_valid), 32'd1);
      next_cycle();
      start    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("rekey_byte_idx", 32'(byte_idx), 32'd0);
      check("rekey_loaded", 32'(loaded), 32'd0);
      check("rekey_in_ready_load", 32'(in_ready), 32'd1);
      check("rekey_pending_valid", 32'(out_valid), 32'd1);
      check("rekey_pending_data", 32'(out_data), 32'h0000_00A3);
      next_cycle();
      out_ready = 1'b1;
      @(negedge clk);
      check("rekey_deliver_valid", 32'(out_valid), 32'd1);
      check("rekey_deliver_data", 32'(out_data), 32'(sb.size() > 0 ? sb[0] : 8'h00));
      if (sb.size() > 0) void'(sb.pop_front());
      next_cycle();
      @(negedge clk);
      check("rekey_drained", 32'(out_valid), 32'd0);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      check("total_reads", 32'(reads), 32'(N_VEC));
      next_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/chacha_stream_ctl.md
Name: chacha_stream_ctl

Overview:
- Host-side initiator for the ChaCha `block` byte interface.
- Loads key, counter and nonce bytes into the block, waits for the block to finish computing, then pulls keystream bytes with `read` pulses.
- XORs each keystream byte with an incoming plaintext byte and emits ciphertext, one byte per cycle.
- Sits between the top-level byte stream and `block`; drives the block's `data_in`/`write`/`read` and samples its `data_out`/`ready`.

Parameters:
- LOAD_BYTES, 48: bytes per (re)key: 32 key, 4 counter, 12 nonce.
- BLOCK_BYTES, 64: keystream bytes per block computation.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a (re)key load.
- in_data  in  8  key byte (LOAD) or plaintext byte (STREAM).
- in_valid  in  1  in_data valid.
- in_ready  out  1  in_data accepted when in_valid & in_ready.
- out_data  out  8  ciphertext byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- blk_data_in  out  8  byte to block data_in.
- blk_write  out  1  block write strobe.
- blk_read  out  1  block read strobe; advances keystream one byte.
- blk_data_out  in  8  current keystream byte from block.
- blk_ready  in  1  block keystream available.
- loaded  out  1  key loaded; keystream session active.
- byte_idx  out  6  keystream byte position within current block.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, load_cnt=0, byte_idx=0, loaded=0, out_valid=0, out_data=0. blk_write, blk_read and in_ready are combinational and are 0 in IDLE.
- States: IDLE, LOAD, SETTLE, WAIT, STREAM.
- IDLE: in_ready=0.
  - start → LOAD; load_cnt=0; loaded=0.
- LOAD: in_ready=1.
  - blk_write = in_valid; blk_data_in = in_data (combinational, same cycle).
  - Each accepted byte increments load_cnt.
  - Gaps (in_valid=0) are tolerated; the block restarts its copy on every write.
  - On accepting byte LOAD_BYTES-1 → SETTLE; byte_idx=0; loaded=1.
- SETTLE: in_ready=0. Wait for blk_ready=0 (block busy), then → WAIT.
  - Guards against a stale ready held from the previous block.
- WAIT: in_ready=0. blk_ready=1 → STREAM.
- STREAM:
  - can_out = !out_valid | out_ready.
  - in_ready = blk_ready & can_out.
  - fire = in_valid & in_ready; blk_read = fire.
  - On fire: out_data <= in_data ^ blk_data_out; out_valid <= 1; byte_idx increments.
  - Latency: 1 cycle input-to-output; throughput 1 byte/cycle with out_ready held high.
  - Fire at byte_idx=BLOCK_BYTES-1: byte_idx wraps to 0, → SETTLE. The block increments its counter and recomputes.
- Output register:
  - out_valid clears on out_ready & !fire.
  - Simultaneous fire and out_ready: register reloads; out_valid stays 1.
  - out_data holds while out_valid & !out_ready.
- start in LOAD/SETTLE/WAIT/STREAM: → LOAD; load_cnt=0; byte_idx=0; loaded=0; no blk_read that cycle. A pending out byte is retained and still delivered.
- start in LOAD restarts the count; the byte accepted that cycle counts as byte 0.
- rst mid-operation: immediate return to reset values; a pending out byte is dropped.
- Widths: load_cnt 6 bits, saturating at LOAD_BYTES-1; byte_idx wraps modulo 64.

Decomposition:
- Shared package chacha_pkg holds:
  - LOAD_BYTES and BLOCK_BYTES constants;
  - the 3-bit state enum (IDLE, LOAD, SETTLE, WAIT, STREAM).
- One sub-module, byte_pipe_reg: single-entry valid/ready output register (data, valid, load, ready).

Test Plan:
- Reset: assert rst 2 cycles with random inputs → out_valid=0, out_data=0x00, in_ready=0, blk_write=0, blk_read=0, loaded=0, byte_idx=0.
- Load: start, then bytes 0x00..0x2F contiguous → blk_write high exactly 48 cycles, blk_data_in equal to each byte, loaded=1 after byte 0x2F, in_ready=0; with 3 idle gaps inserted, still exactly 48 write cycles.
- Stream: block model raises blk_ready 20 cycles after the last write, keystream byte = 0xA5^idx; plaintext 0x00..0x3F with out_ready=1 → out_data = 0xA5^i^i = 0xA5 every cycle, 64 blk_read pulses, 1-cycle latency.
- Backpressure: out_ready=0 for 5 cycles mid-stream → out_data held, in_ready=0, no blk_read; on release, byte sequence continues with no loss or duplicate.
- Block wrap: after the 64th fire → byte_idx=0, in_ready=0 until blk_ready falls then rises; the 65th plaintext 0xFF XORs with the new block's byte 0 (model 0x5A) → 0xA5.
- Rekey: start at byte_idx=10 with out_valid=1 and out_ready=0 → pending byte delivered once out_ready=1, state LOAD, byte_idx=0, loaded=0, no blk_read issued.
